// File: rtl/test_mon_pkg.sv
// rtl/test_mon_pkg.sv - shared types and constants for the test run monitor
//
// Purpose : run-state encoding and tohost exit-word layout used by
//           test_run_monitor and its bench.
// Contents: mon_state_t   - IDLE/RUN/PASS/FAIL state encoding
//           TOHOST_EXIT_BIT - bit of tohost_data that flags an exit write
//           EXIT_CODE_W   - width of the exit code carried above that bit
//           is_exit_word  - decodes a tohost strobe into an exit request

package test_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } mon_state_t;

   localparam int TOHOST_EXIT_BIT = 0;
   localparam int EXIT_CODE_W     = 31;

   // A tohost write only ends the run when the exit flag bit is set;
   // other writes (console traffic etc.) are not exits.
   function automatic logic is_exit_word(input logic valid, input logic [31:0] data);
      return valid && data[TOHOST_EXIT_BIT];
   endfunction

endpackage

// File: rtl/edge_counter.sv
// rtl/edge_counter.sv - saturating rising-edge counter for one watched channel
//
// Purpose : counts 0->1 transitions of din while en is high, saturating at
//           all-ones. Keeps its own registered copy of din as edge history.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset (count and history to 0)
//           clr   - synchronous clear of count; history reloads from din
//           en    - count enable (high while the run is active)
//           din   - watched signal, synchronous to clk
//           count - registered edge count [EDGE_W-1:0]

module edge_counter #(
   parameter int EDGE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [EDGE_W-1:0] count
);

   localparam logic [EDGE_W-1:0] LP_ONE = 1;
   localparam logic [EDGE_W-1:0] LP_MAX = '1;

   logic              r_prev;
   logic [EDGE_W-1:0] r_count;
   logic              w_rise;
   logic              w_sat;

   assign w_rise = din && !r_prev;
   assign w_sat  = (r_count == LP_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_count <= '0;
      end else begin
         // History follows din every cycle; on clr this is what keeps a
         // level already high at start from looking like a fresh edge.
         r_prev <= din;
         if (clr) begin
            r_count <= '0;
         end else if (en && w_rise && !w_sat) begin
            r_count <= r_count + LP_ONE;
         end
      end
   end

   assign count = r_count;

endmodule

// File: rtl/test_run_monitor.sv
// rtl/test_run_monitor.sv - supervises one simulated test run: exit, timeout, activity
//
// Purpose : tracks a test run from start until the DUT writes an exit word
//           to tohost or the cycle budget runs out, reporting progress
//           milestones and per-channel output activity along the way.
// Ports   : clk, rst_n      - clock (rising edge), async active-low reset
//           start           - begin or restart a run
//           watch           - DUT output channels to count rising edges on
//           tohost_valid    - exit-write strobe from the DUT
//           tohost_data     - exit word, bit0 = exit flag, [31:1] = code
//           state           - IDLE/RUN/PASS/FAIL
//           cycle_count     - cycles elapsed in the current run
//           milestone       - one-cycle pulse every MILESTONE run cycles
//           milestone_idx   - number of milestones reached
//           edge_count      - per-channel rising-edge counts, packed
//           exit_code       - code latched from the exit word
//           timed_out       - run failed because the budget expired
//           done            - state is PASS or FAIL

module test_run_monitor
   import test_mon_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CYC_W     = 32,
   parameter int EDGE_W    = 16,
   parameter int MILESTONE = 8,
   parameter int TIMEOUT   = 1000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        watch,
   input  logic                     tohost_valid,
   input  logic [31:0]              tohost_data,
   output logic [1:0]               state,
   output logic [CYC_W-1:0]         cycle_count,
   output logic                     milestone,
   output logic [CYC_W-1:0]         milestone_idx,
   output logic [NUM_CH*EDGE_W-1:0] edge_count,
   output logic [EXIT_CODE_W-1:0]   exit_code,
   output logic                     timed_out,
   output logic                     done
);

   localparam int                PH_W      = $clog2(MILESTONE);
   localparam logic [PH_W-1:0]   LP_PH_ONE = 1;
   localparam logic [PH_W-1:0]   LP_PH_END = PH_W'(MILESTONE - 1);
   localparam logic [CYC_W-1:0]  LP_CYC_1  = 1;
   localparam logic [CYC_W-1:0]  LP_TMO    = CYC_W'(TIMEOUT - 1);

   mon_state_t             r_state;
   logic [CYC_W-1:0]       r_cycle;
   logic [CYC_W-1:0]       r_ms_idx;
   logic [PH_W-1:0]        r_ms_phase;
   logic                   r_milestone;
   logic [EXIT_CODE_W-1:0] r_exit_code;
   logic                   r_timed_out;

   logic                   w_in_run;
   logic                   w_exit;
   logic                   w_exit_pass;
   logic                   w_start_go;
   logic                   w_timeout;
   logic                   w_ms_hit;

   assign w_in_run    = (r_state == ST_RUN);
   assign w_exit      = w_in_run && is_exit_word(tohost_valid, tohost_data);
   assign w_exit_pass = (tohost_data[EXIT_CODE_W:1] == '0);
   // An exit in the same cycle as start wins; the start is dropped.
   assign w_start_go  = start && !w_exit;
   assign w_timeout   = w_in_run && (r_cycle == LP_TMO);
   // Phase counter tracks cycle_count modulo MILESTONE so no divider is
   // needed; a hit means the increment lands on a multiple of MILESTONE.
   assign w_ms_hit    = (r_ms_phase == LP_PH_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cycle     <= '0;
         r_ms_idx    <= '0;
         r_ms_phase  <= '0;
         r_milestone <= 1'b0;
         r_exit_code <= '0;
         r_timed_out <= 1'b0;
      end else begin
         r_milestone <= 1'b0;
         if (w_exit) begin
            // The ending edge does not advance cycle_count, so it reads
            // the cycle on which the run ended.
            r_state     <= w_exit_pass ? ST_PASS : ST_FAIL;
            r_exit_code <= tohost_data[EXIT_CODE_W:1];
         end else if (start) begin
            r_state     <= ST_RUN;
            r_cycle     <= '0;
            r_ms_idx    <= '0;
            r_ms_phase  <= '0;
            r_exit_code <= '0;
            r_timed_out <= 1'b0;
         end else if (w_timeout) begin
            r_state     <= ST_FAIL;
            r_timed_out <= 1'b1;
         end else if (w_in_run) begin
            r_cycle <= r_cycle + LP_CYC_1;
            if (w_ms_hit) begin
               r_ms_phase  <= '0;
               r_milestone <= 1'b1;
               r_ms_idx    <= r_ms_idx + LP_CYC_1;
            end else begin
               r_ms_phase <= r_ms_phase + LP_PH_ONE;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      edge_counter #(
         .EDGE_W (EDGE_W)
      ) u_edge_counter (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (w_start_go),
         .en    (w_in_run),
         .din   (watch[g]),
         .count (edge_count[g*EDGE_W +: EDGE_W])
      );
   end

   assign state         = r_state;
   assign cycle_count   = r_cycle;
   assign milestone     = r_milestone;
   assign milestone_idx = r_ms_idx;
   assign exit_code     = r_exit_code;
   assign timed_out     = r_timed_out;
   assign done          = (r_state == ST_PASS) || (r_state == ST_FAIL);

endmodule

// File: tb/tb_test_run_monitor.sv
// tb/tb_test_run_monitor.sv - self-checking bench for test_run_monitor

module tb_test_run_monitor;

   localparam int NUM_CH = 4;
   localparam int CYC_W  = 32;
   localparam int EDGE_W = 2;
   localparam int MS     = 8;
   localparam int TMO    = 50;
   localparam int EMAX   = (1 << EDGE_W) - 1;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start_i;
   logic [NUM_CH-1:0]        watch_i;
   logic                     tv_i;
   logic [31:0]              td_i;
   logic [1:0]               state;
   logic [CYC_W-1:0]         cycle_count;
   logic                     milestone;
   logic [CYC_W-1:0]         milestone_idx;
   logic [NUM_CH*EDGE_W-1:0] edge_count;
   logic [30:0]              exit_code;
   logic                     timed_out;
   logic                     done;

   int n_vec = 0;
   int n_err = 0;

   test_run_monitor #(
      .NUM_CH    (NUM_CH),
      .CYC_W     (CYC_W),
      .EDGE_W    (EDGE_W),
      .MILESTONE (MS),
      .TIMEOUT   (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start_i),
      .watch         (watch_i),
      .tohost_valid  (tv_i),
      .tohost_data   (td_i),
      .state         (state),
      .cycle_count   (cycle_count),
      .milestone     (milestone),
      .milestone_idx (milestone_idx),
      .edge_count    (edge_count),
      .exit_code     (exit_code),
      .timed_out     (timed_out),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Reference model: run bookkeeping from the rules, with milestones
   // derived arithmetically from the cycle number.
   int          m_state;
   int unsigned m_cyc;
   int unsigned m_idx;
   int          m_edges [NUM_CH];
   logic [NUM_CH-1:0] m_prev;
   logic [30:0] m_code;
   logic        m_to;
   logic        m_ms;

   task automatic model_reset();
      m_state = 0; m_cyc = 0; m_idx = 0; m_prev = '0;
      m_code = '0; m_to = 1'b0; m_ms = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_edges[i] = 0;
   endtask

   task automatic model_step();
      bit run, ex, go, tmo;
      if (!rst_n) begin
         model_reset();
         return;
      end
      run = (m_state == 1);
      ex  = run && tv_i && td_i[0];
      go  = start_i && !ex;
      tmo = run && (m_cyc == TMO - 1);
      for (int i = 0; i < NUM_CH; i++)
         if (run && !go && !m_prev[i] && watch_i[i])
            m_edges[i] = (m_edges[i] >= EMAX) ? EMAX : m_edges[i] + 1;
      m_prev = watch_i;
      m_ms = 1'b0;
      if (ex) begin
         m_state = (td_i[31:1] == 0) ? 2 : 3;
         m_code  = td_i[31:1];
      end else if (go) begin
         m_state = 1; m_cyc = 0; m_idx = 0; m_code = '0; m_to = 1'b0;
         for (int i = 0; i < NUM_CH; i++) m_edges[i] = 0;
      end else if (tmo) begin
         m_state = 3;
         m_to = 1'b1;
      end else if (run) begin
         m_cyc = m_cyc + 1;
         m_ms  = (m_cyc % MS == 0);
         m_idx = m_cyc / MS;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [NUM_CH*EDGE_W-1:0] e;
      e = '0;
      for (int i = 0; i < NUM_CH; i++) e[i*EDGE_W +: EDGE_W] = EDGE_W'(m_edges[i]);
      chk({tag, "_state"}, 64'(state), 64'(m_state));
      chk({tag, "_cyc"},   64'(cycle_count), 64'(m_cyc));
      chk({tag, "_ms"},    64'(milestone), 64'(m_ms));
      chk({tag, "_idx"},   64'(milestone_idx), 64'(m_idx));
      chk({tag, "_edge"},  64'(edge_count), 64'(e));
      chk({tag, "_code"},  64'(exit_code), 64'(m_code));
      chk({tag, "_to"},    64'(timed_out), 64'(m_to));
      chk({tag, "_done"},  64'(done), 64'(m_state >= 2));
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   typedef struct {
      logic [31:0] data;
      int          at;
      logic [1:0]  exp_state;
      logic [30:0] exp_code;
   } exit_vec_t;

   exit_vec_t tbl [5];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      tbl[0] = '{data: 32'h0000_0001, at: 10, exp_state: 2'd2, exp_code: 31'd0};
      tbl[1] = '{data: 32'h0000_000B, at: 10, exp_state: 2'd3, exp_code: 31'd5};
      tbl[2] = '{data: 32'h0000_0003, at: 0,  exp_state: 2'd3, exp_code: 31'd1};
      tbl[3] = '{data: 32'hFFFF_FFFF, at: 30, exp_state: 2'd3, exp_code: 31'h7FFF_FFFF};
      tbl[4] = '{data: 32'h0000_0001, at: TMO - 1, exp_state: 2'd2, exp_code: 31'd0};

      rst_n = 1'b0; start_i = 1'b0; watch_i = '0; tv_i = 1'b0; td_i = '0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_cyc",   64'(cycle_count), 64'd0);
      chk("rst_edge",  64'(edge_count), 64'd0);
      chk("rst_done",  64'(done), 64'd0);

      // milestones after cycles 8, 16, 24
      pulse_start();
      k = 0;
      for (int c = 1; c <= 24; c++) begin
         tick();
         chk("ms_pulse", 64'(milestone), 64'(c % MS == 0));
         if (milestone) k++;
      end
      chk("ms_count", 64'(k), 64'd3);
      chk("ms_idx",   64'(milestone_idx), 64'd3);

      // exit table
      for (int v = 0; v < 5; v++) begin
         pulse_start();
         repeat (tbl[v].at) tick();
         tv_i = 1'b1; td_i = tbl[v].data;
         tick();
         tv_i = 1'b0; td_i = '0;
         chk("ex_state", 64'(state), 64'(tbl[v].exp_state));
         chk("ex_code",  64'(exit_code), 64'(tbl[v].exp_code));
         chk("ex_to",    64'(timed_out), 64'd0);
         chk("ex_cyc",   64'(cycle_count), 64'(tbl[v].at));
         chk("ex_done",  64'(done), 64'd1);
         tick();
         chk("ex_hold",  64'(cycle_count), 64'(tbl[v].at));
      end

      // timeout with no exit
      pulse_start();
      k = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (done) begin k = c; break; end
      end
      chk("tmo_latency", 64'(k), 64'(TMO));
      chk("tmo_state",   64'(state), 64'd3);
      chk("tmo_flag",    64'(timed_out), 64'd1);
      chk("tmo_cyc",     64'(cycle_count), 64'(TMO - 1));
      chk("tmo_done",    64'(done), 64'd1);

      // edge saturation on channel 2; level high at start is not an edge
      watch_i = 4'hF;
      pulse_start();
      tick();
      chk("edge_nospur", 64'(edge_count), 64'd0);
      watch_i = 4'h0;
      tick();
      for (int t = 0; t < 5; t++) begin
         watch_i = 4'h4; tick();
         watch_i = 4'h0; tick();
      end
      chk("edge_sat", 64'(edge_count), 64'h30);

      // bit0=0 write ignored, then restart mid-run
      pulse_start();
      repeat (3) tick();
      tv_i = 1'b1; td_i = 32'h0000_0006;
      tick();
      tv_i = 1'b0; td_i = '0;
      chk("nox_state", 64'(state), 64'd1);
      chk("nox_cyc",   64'(cycle_count), 64'd4);
      repeat (5) tick();
      chk("pre_rs_idx", 64'(milestone_idx), 64'd1);
      pulse_start();
      chk("rs_state", 64'(state), 64'd1);
      chk("rs_cyc",   64'(cycle_count), 64'd0);
      chk("rs_idx",   64'(milestone_idx), 64'd0);

      // start together with exit: exit wins
      repeat (5) tick();
      start_i = 1'b1; tv_i = 1'b1; td_i = 32'h1;
      tick();
      start_i = 1'b0; tv_i = 1'b0; td_i = '0;
      chk("sx_state", 64'(state), 64'd2);
      chk("sx_cyc",   64'(cycle_count), 64'd5);

      // reset mid-run at cycle 20
      pulse_start();
      for (int c = 0; c < 20; c++) begin
         watch_i = 4'(c & 1);
         tick();
      end
      chk("mr_cyc", 64'(cycle_count), 64'd20);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mr_state", 64'(state), 64'd0);
      chk("mr_cnt",   64'(cycle_count), 64'd0);
      chk("mr_edge",  64'(edge_count), 64'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("mr_idle", 64'(state), 64'd0);
      chk("mr_hold", 64'(cycle_count), 64'd0);
      pulse_start();
      tick();
      chk("mr_fresh_state", 64'(state), 64'd1);
      chk("mr_fresh_cyc",   64'(cycle_count), 64'd1);

      // randomized run against the model
      for (int n = 0; n < 1500; n++) begin
         start_i = ($urandom_range(0, 39) == 0);
         watch_i = 4'($urandom);
         tv_i    = ($urandom_range(0, 29) == 0);
         td_i    = {($urandom_range(0, 1) == 1) ? 31'($urandom) : 31'd0, 1'($urandom)};
         tick();
         check_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
